// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, unsigned or two's complement.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish on the first unequal digit instead of always running NDIG steps.
module serial_magnitude_comparator #(
  parameter  int WIDTH = 16,
  parameter  int DIGIT = 2,
  localparam int NDIG  = WIDTH / DIGIT,
  localparam int CW    = $clog2(NDIG) + 1,
  localparam int IW    = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic             A_eq_B,
  output logic [CW-1:0]    cycles
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               decided_q, decided_d;
  logic               res_gt_q, res_gt_d;
  logic               done_q, done_d;
  logic               gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [CW-1:0]      cycles_q, cycles_d;

  logic [DIGIT-1:0]   a_dig, b_dig;
  logic               differ, term;

  assign a_dig  = a_q[int'(idx_q) * DIGIT +: DIGIT];
  assign b_dig  = b_q[int'(idx_q) * DIGIT +: DIGIT];
  assign differ = (a_dig != b_dig);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign term = (idx_q == '0) || (!decided_q && differ);
`else
  assign term = (idx_q == '0);
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    res_gt_d  = res_gt_q;
    done_d    = 1'b0;
    gt_d      = gt_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
    cycles_d  = cycles_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Flipping the sign bit maps two's complement onto offset binary,
          // so the digit loop can always compare unsigned.
          a_d            = A;
          b_d            = B;
          a_d[WIDTH-1]   = A[WIDTH-1] ^ signed_mode;
          b_d[WIDTH-1]   = B[WIDTH-1] ^ signed_mode;
          idx_d          = IW'(NDIG - 1);
          decided_d      = 1'b0;
          res_gt_d       = 1'b0;
          state_d        = RUN;
        end
      end
      RUN: begin
        if (!decided_q && differ) begin
          decided_d = 1'b1;
          res_gt_d  = (a_dig > b_dig);
        end
        if (term) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          gt_d     = decided_d & res_gt_d;
          lt_d     = decided_d & ~res_gt_d;
          eq_d     = ~decided_d;
          cycles_d = CW'(NDIG - int'(idx_q));
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      decided_q <= 1'b0;
      res_gt_q  <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      res_gt_q  <= res_gt_d;
      done_q    <= done_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
      cycles_q  <= cycles_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign A_gt_B = gt_q;
  assign A_lt_B = lt_q;
  assign A_eq_B = eq_q;
  assign cycles = cycles_q;

endmodule
